lsu_dcache_arb: RTL
===================

Name: lsu_dcache_arb

Overview:
- Shares the single LSU->dcache request/response port between two requesters: r0 (the load/store queue, full load/store requests) and r1 (the page-table walker, load-only).
- Arbitrates request issue round-robin and tracks every accepted request in an in-order outstanding FIFO, so each dcache response is routed back to the requester that issued it.
- Sits between the LSQ/PTW and the dcache.
- The dcache returns exactly one response per accepted request (stores included), in request order.

Parameters:
- VIRTUAL_ADDR_LEN, 32, request address width
- XLEN, 32, data width
- LSU_LSQ_SIZE_WIDTH, 2, LSQ index/tag width
- OUTST_DEPTH, 4, maximum in-flight requests
- OUTST_WIDTH, 2, log2(OUTST_DEPTH)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush
- r0_req_valid_i / r0_req_ready_o  in/out  1  LSQ request handshake
- r0_req_opcode_i  in  1  0 load, 1 store
- r0_req_sign_i  in  1  load sign-extend
- r0_req_size_i  in  2  access size
- r0_req_addr_i  in  VIRTUAL_ADDR_LEN  address
- r0_req_data_i  in  XLEN  store data
- r0_req_lsq_index_i  in  LSU_LSQ_SIZE_WIDTH  LSQ tag
- r1_req_valid_i / r1_req_ready_o  in/out  1  PTW request handshake
- r1_req_addr_i  in  VIRTUAL_ADDR_LEN  PTW load address (size fixed 2'b10, unsigned)
- req_valid_o / req_ready_i  out/in  1  dcache request handshake
- req_opcode_o, req_sign_o  out  1  forwarded from the granted requester
- req_size_o  out  2  forwarded from the granted requester
- req_addr_o  out  VIRTUAL_ADDR_LEN  forwarded from the granted requester
- req_data_o  out  XLEN  forwarded from the granted requester
- req_lsq_index_o  out  LSU_LSQ_SIZE_WIDTH  r0 tag; 0 when r1 is granted
- resp_valid_i / resp_ready_o  in/out  1  dcache response handshake
- resp_lsq_index_i  in  LSU_LSQ_SIZE_WIDTH  response tag
- resp_data_i  in  XLEN  response data
- r0_resp_valid_o / r0_resp_ready_i  out/in  1  LSQ response handshake
- r0_resp_lsq_index_o  out  LSU_LSQ_SIZE_WIDTH  LSQ response tag
- r0_resp_data_o  out  XLEN  LSQ response data
- r1_resp_valid_o / r1_resp_ready_i  out/in  1  PTW response handshake
- r1_resp_data_o  out  XLEN  PTW response data
- err_o  out  1  sticky protocol error

Behaviour:
- **Reset (rstn low, asynchronous):** FIFO empty (count=0, rd/wr pointers 0), last_grant=1 (so r0 wins first), lock=0, err_o=0. While rstn is low, all valid and ready outputs are 0.
- **Request path (combinational, zero latency):**
  - The grant selects which requester's fields drive req_*.
  - req_valid_o = granted requester's valid & ~full.
  - rN_req_ready_o = (grant==N) & req_ready_i & ~full.
  - full = (count==OUTST_DEPTH). A pop in the same cycle does not relieve full.
- **Arbitration:**
  - If lock=1, the grant is held on the locked requester.
  - Otherwise, if both requesters are valid, grant the one that is not last_grant; if only one is valid, grant it.
  - Accept = req_valid_o & req_ready_i. On accept: last_grant<=grant, lock<=0, push {src, drop=0}.
  - If req_valid_o & ~req_ready_i: lock<=1 on the current grant. A valid request is never withdrawn by the arbiter.
- **Flush:**
  - While flush=1, r0 is masked from arbitration (r0_req_ready_o=0), and a lock held on r0 is cleared. The dcache also receives flush and tolerates withdrawal of req_valid_o in that cycle.
  - Every in-flight FIFO entry with src=0 gets drop<=1.
  - Entries with src=1 are untouched. A lock held on r1 is kept.
- **Response path:**
  - The FIFO head selects the destination.
  - If head.drop: resp_ready_o=1 and the response is discarded; no rN_resp_valid_o.
  - Else rN_resp_valid_o=resp_valid_i, data and tag passed through, and resp_ready_o=rN_resp_ready_i.
  - Pop on resp_valid_i & resp_ready_o.
- **Simultaneous push and pop:** count unchanged, both pointers advance (wrap modulo OUTST_DEPTH).
- **Errors (err_o, sticky until reset):**
  - resp_valid_i while the FIFO is empty: err_o<=1; the response is consumed (resp_ready_o=1).
  - head.src=0 & ~drop & resp_lsq_index_i != the stored tag: err_o<=1.
- **FIFO entry format:** {src, drop, lsq_index}.

Test Plan:
- **Single requester:** r0 load addr 0x1000, tag 2, dcache ready -> req_valid_o same cycle; count=1. Response data 0xDEADBEEF -> r0_resp_valid_o with tag 2; count=0.
- **Contention:** r0 and r1 valid every cycle, req_ready_i=1 -> grants alternate r0, r1, r0, r1. Once 4 requests are outstanding, req_valid_o=0 until a pop.
- **Lock:** r1 granted with req_ready_i=0 for 3 cycles while r0 becomes valid -> r1 stays granted and req_addr_o is stable. r1 is accepted on cycle 4, then r0 is granted.
- **Flush:** in-flight order r0, r1, r0; flush pulse -> three responses arrive. Only r1_resp_valid_o fires, with the second response's data; the other two are consumed silently; count ends at 0.
- **Full with pop:** count=4 with a response popped in the same cycle as a new valid request -> no accept that cycle; accepted the next cycle.
- **Error:** resp_valid_i with an empty FIFO -> resp_ready_o=1, err_o=1 from the next cycle until rstn is asserted. Asserting rstn mid-traffic clears count and all valids immediately.

Source files
------------

// File: rtl/lsu_dcache_arb.sv
// lsu_dcache_arb
//   Shares the single LSU->dcache request/response port between two
//   requesters: r0 (load/store queue, full load/store requests) and r1
//   (page-table walker, load-only, word size, unsigned).
//   Requests are granted round-robin and every accepted request is recorded
//   in an in-order outstanding FIFO. The dcache answers exactly once per
//   accepted request, in order, so the FIFO head says where each response
//   goes.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   flush                  pipeline flush (masks r0, marks r0 entries dropped)
//   r0_req_*               LSQ request channel (valid/ready + fields)
//   r1_req_*               PTW request channel (valid/ready + address)
//   req_*                  request channel to the dcache
//   resp_*                 response channel from the dcache
//   r0_resp_*              response channel back to the LSQ
//   r1_resp_*              response channel back to the PTW
//   err_o                  sticky protocol error
module lsu_dcache_arb #(
  parameter int VIRTUAL_ADDR_LEN   = 32,
  parameter int XLEN               = 32,
  parameter int LSU_LSQ_SIZE_WIDTH = 2,
  parameter int OUTST_DEPTH        = 4,
  parameter int OUTST_WIDTH        = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,

  input  logic                          r0_req_valid_i,
  output logic                          r0_req_ready_o,
  input  logic                          r0_req_opcode_i,
  input  logic                          r0_req_sign_i,
  input  logic [1:0]                    r0_req_size_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   r0_req_addr_i,
  input  logic [XLEN-1:0]               r0_req_data_i,
  input  logic [LSU_LSQ_SIZE_WIDTH-1:0] r0_req_lsq_index_i,

  input  logic                          r1_req_valid_i,
  output logic                          r1_req_ready_o,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   r1_req_addr_i,

  output logic                          req_valid_o,
  input  logic                          req_ready_i,
  output logic                          req_opcode_o,
  output logic                          req_sign_o,
  output logic [1:0]                    req_size_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]   req_addr_o,
  output logic [XLEN-1:0]               req_data_o,
  output logic [LSU_LSQ_SIZE_WIDTH-1:0] req_lsq_index_o,

  input  logic                          resp_valid_i,
  output logic                          resp_ready_o,
  input  logic [LSU_LSQ_SIZE_WIDTH-1:0] resp_lsq_index_i,
  input  logic [XLEN-1:0]               resp_data_i,

  output logic                          r0_resp_valid_o,
  input  logic                          r0_resp_ready_i,
  output logic [LSU_LSQ_SIZE_WIDTH-1:0] r0_resp_lsq_index_o,
  output logic [XLEN-1:0]               r0_resp_data_o,

  output logic                          r1_resp_valid_o,
  input  logic                          r1_resp_ready_i,
  output logic [XLEN-1:0]               r1_resp_data_o,

  output logic                          err_o
);

  localparam logic [OUTST_WIDTH:0] DEPTH_CNT = (OUTST_WIDTH + 1)'(OUTST_DEPTH);

  typedef struct packed {
    logic                          src;
    logic                          drop;
    logic [LSU_LSQ_SIZE_WIDTH-1:0] lsq_index;
  } outst_entry_t;

  outst_entry_t                fifo_q [OUTST_DEPTH];
  logic [OUTST_WIDTH:0]        count_q;
  logic [OUTST_WIDTH-1:0]      rd_ptr_q;
  logic [OUTST_WIDTH-1:0]      wr_ptr_q;
  logic                        last_grant_q;
  logic                        lock_q;
  logic                        lock_src_q;
  logic                        err_q;

  logic                        full;
  logic                        empty;
  logic                        r0_elig;
  logic                        lock_eff;
  logic                        grant;
  logic                        accept;
  logic                        stall;
  logic                        pop;
  logic                        resp_err;
  outst_entry_t                head;
  outst_entry_t                push_entry;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // Arbitration. A flush removes r0 from contention and breaks a lock held
  // on r0; a lock on r1 survives the flush so the PTW request stays put.
  always_comb begin
    r0_elig  = r0_req_valid_i & ~flush;
    lock_eff = lock_q & ~(flush & ~lock_src_q);
    grant    = ~last_grant_q;
    if (lock_eff) begin
      grant = lock_src_q;
    end else if (r0_elig && r1_req_valid_i) begin
      grant = ~last_grant_q;
    end else if (r1_req_valid_i) begin
      grant = 1'b1;
    end else if (r0_elig) begin
      grant = 1'b0;
    end
  end

  // Request channel: the granted requester's fields drive the dcache. The
  // PTW always issues unsigned word loads with a zero tag.
  always_comb begin
    req_opcode_o    = 1'b0;
    req_sign_o      = 1'b0;
    req_size_o      = 2'b10;
    req_addr_o      = r1_req_addr_i;
    req_data_o      = '0;
    req_lsq_index_o = '0;
    if (!grant) begin
      req_opcode_o    = r0_req_opcode_i;
      req_sign_o      = r0_req_sign_i;
      req_size_o      = r0_req_size_i;
      req_addr_o      = r0_req_addr_i;
      req_data_o      = r0_req_data_i;
      req_lsq_index_o = r0_req_lsq_index_i;
    end
  end

  // Full is judged on the registered count only, so a same-cycle pop never
  // lets a new request in.
  assign req_valid_o    = rstn & ~full & (grant ? r1_req_valid_i : r0_elig);
  assign r0_req_ready_o = rstn & ~grant & ~flush & req_ready_i & ~full;
  assign r1_req_ready_o = rstn & grant & req_ready_i & ~full;
  assign accept         = req_valid_o & req_ready_i;
  assign stall          = req_valid_o & ~req_ready_i;

  always_comb begin
    push_entry           = '0;
    push_entry.src       = grant;
    push_entry.drop      = 1'b0;
    push_entry.lsq_index = grant ? '0 : r0_req_lsq_index_i;
  end

  // Response routing by FIFO head. Responses with nowhere to go (dropped
  // entry, or nothing outstanding) are swallowed so the dcache never stalls.
  always_comb begin
    resp_ready_o    = 1'b0;
    r0_resp_valid_o = 1'b0;
    r1_resp_valid_o = 1'b0;
    if (rstn) begin
      if (empty || head.drop) begin
        resp_ready_o = 1'b1;
      end else if (!head.src) begin
        r0_resp_valid_o = resp_valid_i;
        resp_ready_o    = r0_resp_ready_i;
      end else begin
        r1_resp_valid_o = resp_valid_i;
        resp_ready_o    = r1_resp_ready_i;
      end
    end
  end

  assign r0_resp_lsq_index_o = resp_lsq_index_i;
  assign r0_resp_data_o      = resp_data_i;
  assign r1_resp_data_o      = resp_data_i;

  assign pop      = resp_valid_i & resp_ready_o & ~empty;
  assign resp_err = resp_valid_i &
                    (empty | (~head.src & ~head.drop & (resp_lsq_index_i != head.lsq_index)));

  assign err_o = err_q;

  // Outstanding FIFO, arbitration history and sticky error. Flush marking
  // is written before the push so a slot being refilled takes the new entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < OUTST_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      lock_src_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (flush) begin
        for (int i = 0; i < OUTST_DEPTH; i++) begin
          if (!fifo_q[i].src) begin
            fifo_q[i].drop <= 1'b1;
          end
        end
      end
      if (accept) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (accept) begin
        last_grant_q <= grant;
        lock_q       <= 1'b0;
      end else if (stall) begin
        lock_q     <= 1'b1;
        lock_src_q <= grant;
      end else if (flush && !lock_src_q) begin
        lock_q <= 1'b0;
      end
      if (resp_err) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
